regfile_write_arbiter: RTL

//  Shares the single write port of the 32 x 32-bit register file between two

---
 rtl/regfile_write_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A)
// and load (B) writeback paths; the winning write is registered and issued one cycle later.
module regfile_write_arbiter #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter bit R0_READONLY = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ready,
  input  logic                hold,
  output logic [NUM_REGS-1:0] we,
  output logic [DATA_W-1:0]   wdata,
  output logic                last_a
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [NUM_REGS-1:0] we_r, we_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;
  logic                last_a_r, last_a_s;
  logic                grant_a_s, grant_b_s;
  logic [ADDR_W-1:0]   win_addr_s;
  logic [DATA_W-1:0]   win_data_s;

  // Grant decision: the requester not served last wins a tie
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (!hold) begin
      grant_a_s = a_valid & (!b_valid | !last_a_r);
      grant_b_s = b_valid & (!a_valid |  last_a_r);
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;

  // Next-state and staged-write computation
  always_comb begin
    state_s    = state_r;
    we_s       = {NUM_REGS{1'b0}};
    wdata_s    = wdata_r;
    last_a_s   = last_a_r;
    win_addr_s = grant_a_s ? a_addr : b_addr;
    win_data_s = grant_a_s ? a_data : b_data;
    case (state_r)
      IDLE, ISSUE: begin
        if (grant_a_s || grant_b_s) begin
          state_s  = ISSUE;
          wdata_s  = win_data_s;
          last_a_s = grant_a_s;
          // A write to r0 still consumes the grant but never reaches the file
          if (!(R0_READONLY && (win_addr_s == {ADDR_W{1'b0}}))) begin
            we_s[win_addr_s] = 1'b1;
          end else begin
            we_s = {NUM_REGS{1'b0}};
          end
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      we_r     <= {NUM_REGS{1'b0}};
      wdata_r  <= {DATA_W{1'b0}};
      last_a_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      we_r     <= we_s;
      wdata_r  <= wdata_s;
      last_a_r <= last_a_s;
    end
  end

  assign we     = we_r;
  assign wdata  = wdata_r;
  assign last_a = last_a_r;

endmodule
